inst_fetch: RTL
===============

# inst_fetch

Instruction fetch unit: the requesting side of the instruction-memory port. It owns the program counter, drives the memory's chip-enable and byte address, and captures the combinationally returned instruction word. It hands {pc, instruction} pairs to decode through a valid/ready handshake and a 2-entry buffer, and accepts branch/jump redirects that flush in-flight fetches. It sits between the instruction memory and the decode stage of the MIPS core.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset (first word of the boot image).
- BUF_DEPTH, 2, fetch buffer entries; fixed at 2, other values unsupported.
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  reset: asynchronous assert, active-low, single clock domain.
- im_ce  out  1  instruction-memory chip enable.
- im_addr  out  32  byte address to memory, always word-aligned.
- im_data  in  32  instruction word, valid in the same cycle as im_ce/im_addr; 0 when im_ce=0.
- if_valid  out  1  head buffer entry valid.
- if_pc  out  32  PC of head entry.
- if_inst  out  32  instruction of head entry.
- id_ready  in  1  decode accepts head entry.
- redir_valid  in  1  redirect request (branch/jump/exception vector).
- redir_pc  in  32  redirect target.
- exc_valid  out  1  misaligned-target exception pending (macro only; else tied 0).
- exc_pc  out  32  offending target (macro only; else tied 0).

## Operation
- States: RUN, HALT. Reset enters RUN. HALT exists only with the macro.
- pop = if_valid & id_ready. push = im_ce.
- RUN, no redirect: im_ce = (count < 2) | pop; im_addr = pc; on push, entry {pc, im_data} is written and pc <= pc + 4.
- Buffer is in-order FIFO; if_pc/if_inst/if_valid come from registered head entry. count updates by push − pop.
- Simultaneous push and pop with count == 2: both occur, count stays 2.
- redir_valid (any state, highest priority): buffer cleared (count <= 0), pc <= redir_pc, im_ce = 0 that cycle, pop in that cycle is ignored by the unit (decode must treat the head as squashed). State <= RUN.
- PC arithmetic is 32-bit modulo; 0xFFFF_FFFC + 4 wraps to 0. No address range check; memory decodes the word index.
- im_addr[1:0] is always 2'b00.

## Timing
- Reset values: pc = RESET_PC, count = 0, if_valid = 0, if_pc = 0, if_inst = 0, exc_valid = 0, exc_pc = 0, state = RUN. im_ce = 1, im_addr = RESET_PC combinationally while in reset (benign; nothing is written).
- First fetch in cycle 0 after rst_n deasserts; if_valid = 1 after edge 1.
- Fetch-to-valid latency: 1 cycle. Redirect-to-valid latency: 2 cycles (redirect cycle, fetch cycle).
- With id_ready held 1, sustained throughput is 1 instruction/cycle.
- im_ce has a combinational path from id_ready (via pop).
- rst_n asserted mid-operation: all state cleared immediately, no partial entry survives.

## Configuration
- FETCH_MISALIGN_EXC_EN defined: redirect with redir_pc[1:0] != 0 → buffer cleared, exc_valid <= 1, exc_pc <= redir_pc, state <= HALT. In HALT, im_ce = 0 and if_valid = 0 until the next redir_valid, which clears exc_valid and resumes RUN.
- Undefined: redir_pc[1:0] is forced to 2'b00; exc_valid/exc_pc tied 0; no HALT state.

## Structure
- Shared package fetch_pkg: RESET_PC default, PC_STEP = 4, BUF_DEPTH, fetch_state_t enum {RUN, HALT}, fetch_entry_t struct {pc[31:0], inst[31:0]}.
- Sub-module fetch_buf: 2-entry FIFO of fetch_entry_t with push/pop/flush, count, head outputs. inst_fetch holds PC, FSM, redirect/exception logic.

## Test plan
- Reset release, id_ready = 1, memory image word n = n: if_pc 0,4,8,… with if_inst 0,1,2,… on consecutive cycles from cycle 1.
- id_ready = 0 for 5 cycles after first valid: count reaches 2, im_ce = 0, pc = 8; on release, pcs 0,4,8 delivered without loss or duplication.
- redir_valid with redir_pc = 0x100 while buffer full: im_ce = 0 that cycle, next if_pc = 0x100 two cycles later, old entries never visible.
- Simultaneous pop with full buffer: push occurs same cycle, count stays 2, order preserved.
- With macro: redir_pc = 0x102 → exc_valid = 1, exc_pc = 0x102, im_ce = 0; later redir_pc = 0x200 → exc_valid = 0, fetch resumes at 0x200. Without macro: same stimulus fetches 0x100.
- rst_n pulsed low mid-stream: outputs return to reset values asynchronously; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit and its buffer.
package fetch_pkg;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] PC_STEP   = 32'd4;
  localparam logic [1:0]  BUF_DEPTH = 2'd2;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buf.sv
// Two-entry in-order FIFO of {pc, inst} pairs with push/pop/flush.
// The head entry comes straight from flops, so the fetch outputs are registered.
module fetch_buf
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  input  logic         flush,
  output logic [1:0]   count,
  output logic         head_valid,
  output fetch_entry_t head
);

  fetch_entry_t entry0_q, entry0_d;
  fetch_entry_t entry1_q, entry1_d;
  logic         wr_q, wr_d;
  logic         rd_q, rd_d;
  logic [1:0]   count_q, count_d;

  always_comb begin
    entry0_d = entry0_q;
    entry1_d = entry1_q;
    wr_d     = wr_q;
    rd_d     = rd_q;
    count_d  = count_q;
    if (flush) begin
      wr_d    = 1'b0;
      rd_d    = 1'b0;
      count_d = 2'd0;
    end else begin
      if (push) begin
        if (wr_q) entry1_d = push_entry;
        else      entry0_d = push_entry;
        wr_d = ~wr_q;
      end
      if (pop) rd_d = ~rd_q;
      count_d = count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry0_q <= '0;
      entry1_q <= '0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      entry0_q <= entry0_d;
      entry1_q <= entry1_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      count_q  <= count_d;
    end
  end

  assign count      = count_q;
  assign head_valid = (count_q != 2'd0);
  assign head       = rd_q ? entry1_q : entry0_q;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch unit: PC, memory request, redirect handling and fetch buffer.
// Optional misaligned-redirect exception enabled by FETCH_MISALIGN_EXC_EN.
module inst_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC_P = RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        im_ce,
  output logic [31:0] im_addr,
  input  logic [31:0] im_data,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  input  logic        id_ready,
  input  logic        redir_valid,
  input  logic [31:0] redir_pc,
  output logic        exc_valid,
  output logic [31:0] exc_pc
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [1:0]   count;
  logic         pop;
  logic         buf_flush;
  fetch_entry_t head;
  fetch_entry_t push_entry;

`ifdef FETCH_MISALIGN_EXC_EN
  logic         exc_valid_q, exc_valid_d;
  logic [31:0]  exc_pc_q, exc_pc_d;
`endif

  assign pop = if_valid & id_ready;

  // Redirect wins over everything: it flushes the buffer and suppresses this cycle's fetch.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    im_ce     = 1'b0;
    buf_flush = 1'b0;
`ifdef FETCH_MISALIGN_EXC_EN
    exc_valid_d = exc_valid_q;
    exc_pc_d    = exc_pc_q;
`endif
    if (redir_valid) begin
      buf_flush = 1'b1;
`ifdef FETCH_MISALIGN_EXC_EN
      pc_d = redir_pc;
      if (redir_pc[1:0] != 2'b00) begin
        exc_valid_d = 1'b1;
        exc_pc_d    = redir_pc;
        state_d     = HALT;
      end else begin
        exc_valid_d = 1'b0;
        state_d     = RUN;
      end
`else
      pc_d    = redir_pc & ~32'h3;
      state_d = RUN;
`endif
    end else if (state_q == RUN) begin
      im_ce = (count < BUF_DEPTH) | pop;
      if (im_ce) pc_d = pc_q + PC_STEP;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      pc_q    <= RESET_PC_P;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

`ifdef FETCH_MISALIGN_EXC_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exc_valid_q <= 1'b0;
      exc_pc_q    <= 32'h0;
    end else begin
      exc_valid_q <= exc_valid_d;
      exc_pc_q    <= exc_pc_d;
    end
  end
  assign exc_valid = exc_valid_q;
  assign exc_pc    = exc_pc_q;
`else
  assign exc_valid = 1'b0;
  assign exc_pc    = 32'h0;
`endif

  assign im_addr         = {pc_q[31:2], 2'b00};
  assign push_entry.pc   = im_addr;
  assign push_entry.inst = im_data;

  fetch_buf u_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (im_ce),
    .push_entry (push_entry),
    .pop        (pop & ~redir_valid),
    .flush      (buf_flush),
    .count      (count),
    .head_valid (if_valid),
    .head       (head)
  );

  assign if_pc   = head.pc;
  assign if_inst = head.inst;

endmodule
